// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited imem requests, in-order response queue, NOP bubbles, stall/redirect.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         instF,
    output logic [31:0]         PCF,
    output logic [31:0]         PCPlus4F,
    output logic                validF
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                fetch_fault
`endif
);

    localparam int               PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int               CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

    logic [31:0]      r_pc_req;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_q_count;
    logic [PTR_W-1:0] r_q_rd_ptr;
    logic [PTR_W-1:0] r_q_wr_ptr;
    logic [PTR_W-1:0] r_tag_rd_ptr;
    logic [PTR_W-1:0] r_tag_wr_ptr;
    logic [31:0]      r_q_data [QDEPTH];
    logic [31:0]      r_q_pc   [QDEPTH];
    logic [31:0]      r_tag_pc [QDEPTH];

    logic [31:0]      w_redirect_pc;
    logic             w_misaligned;
    logic             w_halt;
    logic [31:0]      w_fault_pc;
    logic             w_credit;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp_valid;
    logic             w_dropping;
    logic             w_push;
    logic             w_pop;
    logic             w_q_nonempty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_fault;
    logic [31:0] r_fault_pc;

    assign w_redirect_pc = redirect_pc;
    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_halt        = r_fault;
    assign w_fault_pc    = r_fault_pc;
    assign fetch_fault   = r_fault;

    // A misaligned target parks the stage on a NOP carrying the bad PC until an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
        end else if (redirect) begin
            r_fault <= w_misaligned;
            if (w_misaligned) begin
                r_fault_pc <= redirect_pc;
            end
        end
    end
`else
    assign w_redirect_pc = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
    assign w_misaligned  = 1'b0;
    assign w_halt        = 1'b0;
    assign w_fault_pc    = 32'h0;
`endif

    // Credit covers in-flight (including to-be-dropped) plus buffered words, so the queue never overflows.
    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_q_count}) < (CNT_W + 1)'(QDEPTH);
    assign w_req_valid  = !rst && !redirect && !w_halt && w_credit;
    assign w_accept     = w_req_valid && imem.imem_req_ready;
    assign w_rsp_valid  = imem.imem_rsp_valid;
    assign w_dropping   = (r_drop != '0);
    assign w_q_nonempty = (r_q_count != '0);
    assign w_push       = w_rsp_valid && !w_dropping && !redirect;
    assign w_pop        = w_q_nonempty && !stall && !redirect;

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_req      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_q_count     <= '0;
            r_q_rd_ptr    <= '0;
            r_q_wr_ptr    <= '0;
            r_tag_rd_ptr  <= '0;
            r_tag_wr_ptr  <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp_valid);
            if (redirect) begin
                // Everything still in flight after this edge belongs to the old path.
                r_drop       <= r_outstanding - CNT_W'(w_rsp_valid);
                r_q_count    <= '0;
                r_q_rd_ptr   <= '0;
                r_q_wr_ptr   <= '0;
                r_tag_rd_ptr <= '0;
                r_tag_wr_ptr <= '0;
                if (!w_misaligned) begin
                    r_pc_req <= w_redirect_pc;
                end
            end else begin
                if (w_rsp_valid && w_dropping) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
                r_q_count <= r_q_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_push) begin
                    r_q_wr_ptr   <= ptr_inc(r_q_wr_ptr);
                    r_tag_rd_ptr <= ptr_inc(r_tag_rd_ptr);
                end
                if (w_pop) begin
                    r_q_rd_ptr <= ptr_inc(r_q_rd_ptr);
                end
                if (w_accept) begin
                    r_tag_wr_ptr <= ptr_inc(r_tag_wr_ptr);
                    r_pc_req     <= r_pc_req + 32'd4;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_accept && (r_tag_wr_ptr == PTR_W'(gi))) begin
                    r_tag_pc[gi] <= r_pc_req;
                end
                if (w_push && (r_q_wr_ptr == PTR_W'(gi))) begin
                    r_q_data[gi] <= imem.imem_rsp_data;
                    r_q_pc[gi]   <= r_tag_pc[r_tag_rd_ptr];
                end
            end
        end
    endgenerate

    always_comb begin
        validF   = w_q_nonempty || w_halt;
        instF    = NOP;
        PCF      = 32'h0;
        PCPlus4F = 32'h0;
        if (w_halt) begin
            PCF      = w_fault_pc;
            PCPlus4F = w_fault_pc + 32'd4;
        end else if (w_q_nonempty) begin
            instF    = r_q_data[r_q_rd_ptr];
            PCF      = r_q_pc[r_q_rd_ptr];
            PCPlus4F = r_q_pc[r_q_rd_ptr] + 32'd4;
        end
    end

endmodule
